// File: rtl/gpu_pkg.sv
// Shared GPU definitions: display geometry, pixel width, fill FSM states and
// the {v, h} VRAM address packing used by the CPU-side port.
package gpu_pkg;
    localparam int H_RES  = 200;
    localparam int V_RES  = 150;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    function automatic logic [15:0] pack_addr(input logic [7:0] v, input logic [7:0] h);
        return {v, h};
    endfunction
endpackage

// File: rtl/fill_addr_gen.sv
// Row-major pixel walker for the fill engine: latches the clipped rectangle
// bounds and steps h/v one pixel per advance.
module fill_addr_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [8:0] i_x_end,
    input  logic [8:0] i_y_end,
    input  logic       i_adv,
    output logic [7:0] o_h,
    output logic [7:0] o_v,
    output logic       o_last
);
    logic [7:0] r_x0;
    logic [8:0] r_x_end;
    logic [8:0] r_y_end;
    logic [7:0] r_h;
    logic [7:0] r_v;
    logic       w_h_wrap;
    logic       w_v_last;

    // Bounds are exclusive and may equal 200/150, so compare in 9 bits.
    assign w_h_wrap = ({1'b0, r_h} + 9'd1) == r_x_end;
    assign w_v_last = ({1'b0, r_v} + 9'd1) == r_y_end;
    assign o_last   = w_h_wrap & w_v_last;
    assign o_h      = r_h;
    assign o_v      = r_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0    <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
            r_h     <= '0;
            r_v     <= '0;
        end else if (i_load) begin
            r_x0    <= i_x0;
            r_x_end <= i_x_end;
            r_y_end <= i_y_end;
            r_h     <= i_x0;
            r_v     <= i_y0;
        end else if (i_adv) begin
            if (w_h_wrap) begin
                r_h <= r_x0;
                r_v <= r_v + 8'd1;
            end else begin
                r_h <= r_h + 8'd1;
            end
        end
    end
endmodule

// File: rtl/vram_arbiter_fill.sv
// Shares the CPU-side VRAM port between CPU single accesses and a rectangle
// fill engine, alternating grants when both request in the same cycle.
module vram_arbiter_fill
    import gpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_we_i,
    input  logic              cpu_re_i,
    input  logic [15:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_ready_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              fill_start_i,
    input  logic [7:0]        fill_x0_i,
    input  logic [7:0]        fill_y0_i,
    input  logic [7:0]        fill_w_i,
    input  logic [7:0]        fill_h_i,
    input  logic [DATA_W-1:0] fill_color_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              vram_we_o,
    output logic              vram_re_o,
    output logic [15:0]       vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);
    fill_state_t       r_state;
    logic [DATA_W-1:0] r_color;
    logic              r_last_fill;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_rdata;

    logic [8:0]  w_x_sum, w_y_sum, w_x_end, w_y_end;
    logic        w_empty, w_accept, w_load;
    logic        w_cpu_req, w_fill_req, w_cpu_gnt, w_fill_gnt;
    logic [7:0]  w_h, w_v;
    logic        w_last;

    assign w_x_sum  = {1'b0, fill_x0_i} + {1'b0, fill_w_i};
    assign w_y_sum  = {1'b0, fill_y0_i} + {1'b0, fill_h_i};
    assign w_x_end  = (w_x_sum > 9'(H_RES)) ? 9'(H_RES) : w_x_sum;
    assign w_y_end  = (w_y_sum > 9'(V_RES)) ? 9'(V_RES) : w_y_sum;
    assign w_empty  = (fill_w_i == 8'd0) || (fill_h_i == 8'd0) ||
                      ({1'b0, fill_x0_i} >= 9'(H_RES)) || ({1'b0, fill_y0_i} >= 9'(V_RES));
    assign w_accept = (r_state == ST_IDLE) && fill_start_i;
    assign w_load   = w_accept && !w_empty;

    // CPU request is masked during reset so every output reads zero while rst_n is low.
    assign w_cpu_req  = (cpu_we_i | cpu_re_i) & rst_n;
    assign w_fill_req = (r_state == ST_RUN);
    assign w_cpu_gnt  = w_cpu_req & (~w_fill_req | r_last_fill);
    assign w_fill_gnt = w_fill_req & ~w_cpu_gnt;

    fill_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_x0    (fill_x0_i),
        .i_y0    (fill_y0_i),
        .i_x_end (w_x_end),
        .i_y_end (w_y_end),
        .i_adv   (w_fill_gnt),
        .o_h     (w_h),
        .o_v     (w_v),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_color <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_state <= w_empty ? ST_DONE : ST_RUN;
                    r_color <= fill_color_i;
                end
                ST_RUN:  if (w_fill_gnt && w_last) r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_fill <= 1'b1;
            r_rd_pend   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_cpu_req && w_fill_req) r_last_fill <= w_fill_gnt;
            r_rd_pend <= w_cpu_gnt & cpu_re_i & ~cpu_we_i;
            if (r_rd_pend) r_rdata <= vram_data_i;
        end
    end

    assign fill_busy_o  = (r_state == ST_RUN);
    assign fill_done_o  = (r_state == ST_DONE);
    assign cpu_ready_o  = w_cpu_gnt;
    assign cpu_rvalid_o = r_rd_pend;
    assign cpu_rdata_o  = r_rd_pend ? vram_data_i : r_rdata;

    always_comb begin
        vram_we_o   = 1'b0;
        vram_re_o   = 1'b0;
        vram_addr_o = '0;
        vram_data_o = '0;
        if (w_cpu_gnt) begin
            vram_we_o   = cpu_we_i;
            vram_re_o   = cpu_re_i & ~cpu_we_i;
            vram_addr_o = cpu_addr_i;
            vram_data_o = cpu_data_i;
        end else if (w_fill_gnt) begin
            vram_we_o   = 1'b1;
            vram_addr_o = pack_addr(w_v, w_h);
            vram_data_o = r_color;
        end
    end
endmodule

// File: tb/tb_vram_arbiter_fill.sv
// Directed and randomized checks of vram_arbiter_fill against a pixel-queue
// reference model with a behavioural VRAM attached to the port.
module tb_vram_arbiter_fill;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_we_i = 0, cpu_re_i = 0;
    logic [15:0] cpu_addr_i = 0;
    logic [11:0] cpu_data_i = 0;
    logic        cpu_ready_o, cpu_rvalid_o;
    logic [11:0] cpu_rdata_o;
    logic        fill_start_i = 0;
    logic [7:0]  fill_x0_i = 0, fill_y0_i = 0, fill_w_i = 0, fill_h_i = 0;
    logic [11:0] fill_color_i = 0;
    logic        fill_busy_o, fill_done_o;
    logic        vram_we_o, vram_re_o;
    logic [15:0] vram_addr_o;
    logic [11:0] vram_data_o;
    logic [11:0] vram_data_i = 0;

    always #5 clk = ~clk;

    vram_arbiter_fill dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we_i(cpu_we_i), .cpu_re_i(cpu_re_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .fill_start_i(fill_start_i), .fill_x0_i(fill_x0_i), .fill_y0_i(fill_y0_i),
        .fill_w_i(fill_w_i), .fill_h_i(fill_h_i), .fill_color_i(fill_color_i),
        .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
        .vram_we_o(vram_we_o), .vram_re_o(vram_re_o), .vram_addr_o(vram_addr_o),
        .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
    );

    // Behavioural VRAM on the GPU side: synchronous write, 1-cycle read.
    logic [11:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = 12'h000;
    always @(posedge clk) begin
        if (vram_we_o) mem[vram_addr_o] <= vram_data_o;
        if (vram_re_o) vram_data_i <= mem[vram_addr_o];
    end

    int          ncmp = 0, nerr = 0;
    logic [15:0] fq[$];
    logic [11:0] f_col;
    bit          last_fill = 1'b1, done_due = 1'b0, rv_due = 1'b0;
    logic [11:0] rv_val = 0, hold = 0;
    logic [11:0] ref_mem[int];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        last_fill = 1'b1; done_due = 1'b0; rv_due = 1'b0; hold = 12'h000;
    endtask

    // Expected pixel list straight from the clipping rule.
    task automatic model_start(input int x0, input int y0, input int w, input int h);
        int xe, ye;
        xe = (x0 + w < 200) ? x0 + w : 200;
        ye = (y0 + h < 150) ? y0 + h : 150;
        if (w == 0 || h == 0 || x0 >= 200 || y0 >= 150) return;
        for (int v = y0; v < ye; v++)
            for (int x = x0; x < xe; x++)
                fq.push_back(16'(v * 256 + x));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"},  cpu_ready_o,  0);
        chk({tag, "_rvalid"}, cpu_rvalid_o, 0);
        chk({tag, "_rdata"},  cpu_rdata_o,  0);
        chk({tag, "_busy"},   fill_busy_o,  0);
        chk({tag, "_done"},   fill_done_o,  0);
        chk({tag, "_we"},     vram_we_o,    0);
        chk({tag, "_re"},     vram_re_o,    0);
        chk({tag, "_addr"},   vram_addr_o,  0);
        chk({tag, "_data"},   vram_data_o,  0);
    endtask

    // One cycle: inputs already driven at posedge+1; check at negedge, then advance model.
    task automatic tick();
        bit creq, freq, gc, gf, ewe, nd, idle;
        logic [15:0] ea;
        logic [11:0] ed;
        #4;
        creq = cpu_we_i | cpu_re_i;
        freq = fq.size() != 0;
        idle = !freq && !done_due;
        gc   = creq && (!freq || last_fill);
        gf   = freq && !gc;
        ewe  = gc ? cpu_we_i : gf;
        ea   = gc ? cpu_addr_i : (gf ? fq[0] : 16'h0);
        ed   = gc ? cpu_data_i : (gf ? f_col : 12'h0);
        chk("ready",  cpu_ready_o, gc);
        chk("we",     vram_we_o, ewe);
        chk("re",     vram_re_o, gc && cpu_re_i && !cpu_we_i);
        chk("addr",   vram_addr_o, ea);
        if (ewe || (!gc && !gf)) chk("wdata", vram_data_o, ed);
        chk("busy",   fill_busy_o, freq);
        chk("done",   fill_done_o, done_due);
        chk("rvalid", cpu_rvalid_o, rv_due);
        chk("rdata",  cpu_rdata_o, rv_due ? rv_val : hold);
        @(posedge clk);
        if (creq && freq) last_fill = gf;
        if (rv_due) hold = rv_val;
        rv_due = 1'b0;
        if (gc && cpu_we_i) ref_mem[int'(cpu_addr_i)] = cpu_data_i;
        if (gc && cpu_re_i && !cpu_we_i) begin
            rv_due = 1'b1;
            rv_val = ref_mem.exists(int'(cpu_addr_i)) ? ref_mem[int'(cpu_addr_i)] : 12'h000;
        end
        nd = gf && fq.size() == 1;
        if (gf) void'(fq.pop_front());
        if (fill_start_i && idle) begin
            f_col = fill_color_i;
            model_start(int'(fill_x0_i), int'(fill_y0_i), int'(fill_w_i), int'(fill_h_i));
            if (fq.size() == 0) nd = 1'b1;
        end
        done_due = nd;
        #1;
    endtask

    task automatic pulse_start(input int x0, input int y0, input int w, input int h, input logic [11:0] c);
        fill_x0_i = 8'(x0); fill_y0_i = 8'(y0); fill_w_i = 8'(w); fill_h_i = 8'(h);
        fill_color_i = c; fill_start_i = 1'b1;
        tick();
        fill_start_i = 1'b0;
        fill_x0_i = 8'($urandom); fill_y0_i = 8'($urandom);
        fill_w_i = 8'($urandom); fill_h_i = 8'($urandom); fill_color_i = 12'($urandom);
    endtask

    // Run until the model is idle; rnd_cpu adds random CPU traffic each cycle.
    task automatic run_fill(input bit rnd_cpu);
        int n = 0;
        while ((fq.size() != 0 || done_due) && n < 400) begin
            if (rnd_cpu) begin
                cpu_we_i = ($urandom_range(0, 2) == 0);
                cpu_re_i = ($urandom_range(0, 2) == 0);
                cpu_addr_i = {8'($urandom_range(0, 149)), 8'($urandom_range(0, 199))};
                cpu_data_i = 12'($urandom);
            end
            tick();
            n++;
        end
        chk("fill_timeout", 16'(n < 400), 1);
        cpu_we_i = 0; cpu_re_i = 0;
        tick();
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        cpu_we_i = 1; cpu_addr_i = 16'h0203; cpu_data_i = 12'hABC;
        tick();
        cpu_we_i = 0; cpu_re_i = 1;
        tick();
        cpu_re_i = 0;
        tick();
        chk("rdata_hold", cpu_rdata_o, 12'hABC);

        pulse_start(10, 5, 3, 2, 12'hF00);
        run_fill(1'b0);
        chk("fill_pix_10_5", 16'(mem[16'h050A]), 12'hF00);
        chk("fill_pix_12_6", 16'(mem[16'h060C]), 12'hF00);

        pulse_start(198, 149, 5, 5, 12'h0F0);
        run_fill(1'b0);
        pulse_start(200, 3, 4, 4, 12'h00F);
        run_fill(1'b0);
        pulse_start(7, 3, 0, 4, 12'h00F);
        run_fill(1'b0);

        cpu_we_i = 1; cpu_addr_i = 16'h1111; cpu_data_i = 12'h123;
        pulse_start(50, 60, 4, 1, 12'h0F0);
        for (int i = 0; i < 10; i++) begin
            cpu_addr_i = 16'h1111 + 16'(i);
            tick();
        end
        cpu_we_i = 0;
        run_fill(1'b0);

        pulse_start(20, 20, 3, 3, 12'h555);
        for (int i = 0; i < 3; i++) begin
            fill_start_i = 1; fill_x0_i = 8'd90; fill_y0_i = 8'd90;
            fill_w_i = 8'd9; fill_h_i = 8'd9; fill_color_i = 12'hEEE;
            tick();
        end
        fill_start_i = 0;
        run_fill(1'b0);
        chk("no_second_fill", 16'(mem[16'h5A5A]), 12'h000);

        pulse_start(0, 100, 10, 1, 12'h777);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midfill_reset");
        model_reset();
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk("abort_px3", 16'(mem[16'h6403]), 12'h000);
        pulse_start(30, 40, 2, 2, 12'h3C3);
        run_fill(1'b0);

        for (int r = 0; r < 10; r++) begin
            int x0, y0;
            x0 = (r % 2) ? $urandom_range(190, 203) : $urandom_range(0, 180);
            y0 = (r % 2) ? $urandom_range(143, 152) : $urandom_range(0, 140);
            pulse_start(x0, y0, $urandom_range(0, 9), $urandom_range(0, 4), 12'($urandom));
            run_fill(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/vram_arbiter_fill.md
# vram_arbiter_fill

Shares the GPU's single CPU-side VRAM port (write/read port 2, address format {v[7:0], h[7:0]}) between the CPU bus and a built-in rectangle-fill engine. The CPU issues single reads and writes; the fill engine streams one pixel write per granted cycle to paint an axis-aligned rectangle in one colour. The block sits between the CPU memory-mapped I/O decode and the `GPU` VRAM inputs.

## Interface
- H_RES, 200, display width in pixels
- V_RES, 150, display height in pixels
- DATA_W, 12, pixel width (RGB444)

- clk  in  1  system clock (same clock as the GPU)
- rst_n  in  1  asynchronous, active-low reset
- cpu_we_i  in  1  CPU write request, held until accepted
- cpu_re_i  in  1  CPU read request, held until accepted
- cpu_addr_i  in  16  CPU pixel address {v, h}
- cpu_data_i  in  DATA_W  CPU write data
- cpu_ready_o  out  1  CPU request accepted this cycle
- cpu_rdata_o  out  DATA_W  CPU read data
- cpu_rvalid_o  out  1  cpu_rdata_o valid (one-cycle pulse)
- fill_start_i  in  1  start pulse; rectangle parameters sampled this cycle
- fill_x0_i, fill_y0_i  in  8 each  top-left corner
- fill_w_i, fill_h_i  in  8 each  width, height in pixels
- fill_color_i  in  DATA_W  fill colour
- fill_busy_o  out  1  engine active
- fill_done_o  out  1  one-cycle completion pulse
- vram_we_o, vram_re_o  out  1 each  to GPU vram_we_i / vram_re_i
- vram_addr_o  out  16  to GPU vram_addr_i
- vram_data_o  out  DATA_W  to GPU vram_data_i
- vram_data_i  in  DATA_W  from GPU vram_data_o

## Operation
- FSM states: IDLE, RUN, DONE. IDLE -> RUN on fill_start_i with non-empty clipped rectangle; IDLE -> DONE on fill_start_i with empty clipped rectangle; RUN -> DONE when the last pixel write is granted; DONE -> IDLE unconditionally.
- fill_start_i ignored outside IDLE; parameters latched on acceptance, later input changes have no effect.
- Clipping (9-bit arithmetic): x_end = min(x0+w, H_RES), y_end = min(y0+h, V_RES). Empty if w==0, h==0, x0>=H_RES or y0>=V_RES; empty fill performs zero writes.
- Scan order row-major: h from x0 to x_end-1, then v increments, h reloads x0. Total writes = (x_end-x0)*(y_end-y0).
- Arbitration per cycle, requesters CPU (cpu_we_i|cpu_re_i) and fill (state RUN):
  - single requester: granted.
  - both: alternate; a 1-bit last_grant register gives the grant to whichever was not granted last contended cycle. Reset value: last_grant = fill (CPU wins first contention).
- cpu_we_i and cpu_re_i both high: treated as write only.
- Fill pixel counter advances only on a fill grant; a stalled fill holds its address.
- vram_* outputs are a combinational mux of the granted requester; all zero when no grant.

## Timing
- Reset values: cpu_ready_o 0, cpu_rvalid_o 0, cpu_rdata_o 0, fill_busy_o 0, fill_done_o 0, vram_we_o 0, vram_re_o 0, vram_addr_o 0, vram_data_o 0; FSM IDLE.
- cpu_ready_o combinational, high in the cycle the CPU is granted.
- Read latency: CPU read granted cycle N -> cpu_rvalid_o high and cpu_rdata_o = vram_data_i in cycle N+1 (VRAM read is synchronous, 1 cycle); cpu_rdata_o holds its value until the next read.
- fill_start_i accepted cycle N -> fill_busy_o high from N+1, first write no earlier than N+1.
- Uncontended fill of P pixels: writes in cycles N+1..N+P, fill_done_o in N+P+1, fill_busy_o low from N+P+1.
- Empty fill: fill_done_o in N+1, fill_busy_o never rises.
- fill_busy_o and fill_done_o never high simultaneously.
- rst_n asserted mid-fill: immediate abort, no fill_done_o, outputs to reset values.

## Structure
- Shared `gpu_pkg`: H_RES, V_RES, DATA_W, fill FSM state enum, {v,h} address packing.
- One sub-module: `fill_addr_gen` (latched x0/x_end/y_end, h/v counters, advance input, last-pixel flag).

## Test plan
- Reset then CPU write addr 16'h0203 data 12'hABC, then read same addr -> ready on both, rvalid one cycle after read grant with 12'hABC, vram_addr_o 16'h0203.
- Fill x0=10,y0=5,w=3,h=2,color 12'hF00, no CPU traffic -> 6 consecutive writes {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}, done 7 cycles after start.
- Fill x0=198,y0=149,w=5,h=5 -> exactly 2 writes ({149,198},{149,199}); x0=200 or w=0 -> zero writes, done cycle N+1.
- Continuous CPU writes during a 4-pixel fill -> grants alternate CPU, fill, CPU, ...; fill completes after 8 contended cycles with correct addresses.
- fill_start_i reasserted with new params while busy -> ignored, original rectangle completes unchanged.
- rst_n low mid-fill at pixel 3 of 10 -> all outputs 0 asynchronously, no done pulse; new fill after release runs from its own x0,y0.
